adc_readout: RTL and testbench
==============================

ADC_READOUT -- requirements
Module: adc_readout

Interface
REQ-001 Parameter DW, 12, ADC sample width in bits.
REQ-002 Parameter FIFO_DEPTH, 4, output FIFO depth in words; power of two, 2 or more.
REQ-003 clk  input  1  system clock, the same clock that drives the clock generator.
REQ-004 reset_n  input  1  reset; one clock; synchronous, active-low.
REQ-005 adcsync  input  1  one-cycle strobe from the clock generator, once per ADC clock period, marking a valid ADC sample.
REQ-006 adc_data  input  DW  ADC sample bus, stable while adcsync is high.
REQ-007 adc_or  input  1  ADC overrange flag, qualified by adcsync.
REQ-008 start  input  1  acquisition trigger, level-sampled each clk.
REQ-009 abort  input  1  terminates an acquisition.
REQ-010 holdoff  input  8  number of adcsync strobes skipped after start.
REQ-011 length  input  8  samples per acquisition; 0 means 256.
REQ-012 dout  output  16  {first, last, overrange, 1'b0, sample[11:0]}.
REQ-013 dout_valid  output  1  dout holds a word.
REQ-014 dout_ready  input  1  consumer accepts the word.
REQ-015 busy  output  1  acquisition in progress.
REQ-016 overflow  output  1  sticky; a sample was lost on a full FIFO.

Function
REQ-017 FSM states: IDLE, HOLD, ACQ.
- IDLE -> HOLD on start=1; holdoff and length are latched at that edge.
REQ-018 HOLD behaviour:
- The holdoff counter decrements on each adcsync.
- HOLD -> ACQ on the edge where the count reaches 0.
- With holdoff=0, the FSM goes IDLE -> ACQ directly.
REQ-019 ACQ captures adc_data and adc_or on each adcsync, pushes one word, and decrements the remaining count.
- ACQ -> IDLE on the push of the last word.
REQ-020 Word flags:
- first=1 on the first pushed word of an acquisition only.
- last=1 on the final word only.
- With length=1, both first and last are 1 on the single word.
REQ-021 start is ignored while busy=1, and ignored again on the same edge that busy falls.
REQ-022 abort=1 in HOLD or ACQ forces IDLE on the next edge.
- No word is pushed on that edge.
- Words already queued remain in the FIFO.
- abort has priority over adcsync.
REQ-023 busy=1 exactly in HOLD and ACQ.
REQ-024 Capture-to-output latency:
- A sample captured on edge N is visible on dout with dout_valid=1 after edge N if the FIFO was empty.
- That is one clk of latency.
REQ-025 Handshake:
- A word is transferred on each edge with dout_valid=1 and dout_ready=1.
- dout and dout_valid hold stable while dout_ready=0.
REQ-026 On an edge with a push and a pop together, FIFO occupancy is unchanged, and this holds even when the FIFO is full.
REQ-027 Push to a full FIFO without a simultaneous pop:
- The sample is dropped and overflow is set.
- The acquisition continues, and the remaining count still decrements.
- If the dropped sample carried last, the FSM still returns to IDLE.
REQ-028 overflow clears only on reset.
REQ-029 adcsync outside ACQ is ignored in terms of data; in HOLD it only decrements the holdoff counter.
REQ-030 The remaining-count width is 9 bits so that length=0 loads 256; the counter does not wrap.

Reset
REQ-031 While reset_n=0 at a clk edge, the block is cleared:
- FSM in IDLE, all counters 0.
- FIFO empty, dout_valid=0, dout=0.
- busy=0, overflow=0.
REQ-032 Reset in the middle of an acquisition discards the acquisition and all FIFO contents; there is no partial flush.
REQ-033 start asserted during reset is not remembered.

Structure
REQ-034 Package adc_readout_pkg holds:
- the FSM state enum;
- the word bit positions (FIRST=15, LAST=14, OR=13, sample 11:0);
- the length-0-means-256 constant.
REQ-035 One sub-module, sync_fifo:
- parameterised width and depth;
- synchronous active-low reset;
- full and empty flags;
- push/pop on the same edge allowed.
REQ-036 All sequential logic is on the rising edge of clk; there are no other clocks or derived clock enables.

Verification
REQ-037 Basic acquisition:
- Stimulus: holdoff=2, length=3, start pulse, adcsync every 4 clk with data 0x101/0x102/0x103/0x104/0x105, dout_ready=1.
- Response: words 0x8103, 0x0104, 0x4105.
- busy falls on the edge of the last push.
REQ-038 Backpressure and overflow:
- Stimulus: FIFO_DEPTH=4, length=6, holdoff=0, dout_ready=0.
- Response: 4 words retained, overflow=1, busy returns to 0.
- Then dout_ready=1 yields the first 4 samples in order, and overflow stays 1.
REQ-039 Single-sample acquisition:
- Stimulus: length=1, adc_or=1, sample 0xFFF.
- Response: word 0xEFFF.
REQ-040 length=0:
- Stimulus: length=0.
- Response: exactly 256 words; first on word 0 only, last on word 255 only.
REQ-041 Abort and restart:
- Stimulus: abort during ACQ after 2 of 5 samples, then a new start.
- Response: 2 queued words drain with last=0.
- The new acquisition begins with first=1.
REQ-042 Reset during transfer:
- Stimulus: reset_n=0 for 1 clk with 3 words queued during ACQ.
- Response: dout_valid=0, busy=0, overflow=0 after the edge; the queued words are discarded.

Source files
------------

// File: rtl/adc_readout_pkg.sv
// ============================================================================
// Module      : adc_readout_pkg
// Description : Shared types, word layout and count constants for adc_readout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_readout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_ACQ  = 2'd2
    } state_t;

    localparam int c_WORD_W     = 16;
    localparam int c_SAMPLE_W   = 12;
    localparam int c_CNT_W      = 9;
    localparam int c_BIT_FIRST  = 15;
    localparam int c_BIT_LAST   = 14;
    localparam int c_BIT_OR     = 13;
    localparam int c_SAMPLE_MSB = 11;
    localparam int c_SAMPLE_LSB = 0;

    // A programmed length of zero stands for a full 256-sample acquisition.
    localparam logic [c_CNT_W-1:0] c_LEN_ZERO_COUNT = 9'd256;

    function automatic logic [c_WORD_W-1:0] pack_word(
        input logic                  first,
        input logic                  last,
        input logic                  ovr,
        input logic [c_SAMPLE_W-1:0] sample
    );
        logic [c_WORD_W-1:0] w;
        w                            = '0;
        w[c_BIT_FIRST]               = first;
        w[c_BIT_LAST]                = last;
        w[c_BIT_OR]                  = ovr;
        w[c_SAMPLE_MSB:c_SAMPLE_LSB] = sample;
        return w;
    endfunction

    function automatic logic [c_CNT_W-1:0] load_count(input logic [7:0] len);
        return (len == 8'd0) ? c_LEN_ZERO_COUNT : {1'b0, len};
    endfunction

endpackage

`default_nettype wire

// File: rtl/adc_readout_if.sv
// ============================================================================
// Module      : adc_readout_if
// Description : Valid/ready word stream leaving the ADC readout block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adc_readout_if;
    import adc_readout_pkg::*;

    logic [c_WORD_W-1:0] dout;
    logic                dout_valid;
    logic                dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );

endinterface

`default_nettype wire

// File: rtl/adc_readout_sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with full/empty flags; push and pop may share an edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] din,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int               c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_DEPTH = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign full      = (r_count == c_DEPTH);
    assign empty     = (r_count == '0);
    assign w_pop_ok  = pop && !empty;
    // A full FIFO still accepts a push when a word leaves on the same edge.
    assign w_push_ok = push && (!full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= din;
    end

    // Gated so the output reads zero whenever nothing is queued.
    assign dout = empty ? '0 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/adc_readout.sv
// ============================================================================
// Module      : adc_readout
// Description : Triggered ADC acquisition with holdoff, flagged words and output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_readout
    import adc_readout_pkg::*;
#(
    parameter int DW         = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    input  wire logic          adcsync,
    input  wire logic [DW-1:0] adc_data,
    input  wire logic          adc_or,
    input  wire logic          start,
    input  wire logic          abort,
    input  wire logic [7:0]    holdoff,
    input  wire logic [7:0]    length,
    output logic               busy,
    output logic               overflow,
    adc_readout_if.master      stream
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_hold_cnt;
    logic [7:0]           w_hold_nxt;
    logic [c_CNT_W-1:0]   r_remain;
    logic [c_CNT_W-1:0]   w_remain_nxt;
    logic                 r_first;
    logic                 w_first_nxt;
    logic                 r_overflow;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;
    logic [c_SAMPLE_W-1:0] w_sample;
    logic [c_WORD_W-1:0]  w_word;
    logic [c_WORD_W-1:0]  w_fifo_dout;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;

    if (DW >= c_SAMPLE_W) begin : g_sample_wide
        assign w_sample = adc_data[c_SAMPLE_W-1:0];
    end else begin : g_sample_narrow
        assign w_sample = {{(c_SAMPLE_W - DW){1'b0}}, adc_data};
    end

    assign w_word = pack_word(r_first, (r_remain == 9'd1), adc_or, w_sample);
    assign w_pop  = !w_fifo_empty && stream.dout_ready;
    // A sample is lost only when the FIFO is full and nothing drains this edge.
    assign w_drop = w_push && w_fifo_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_remain   <= '0;
            r_first    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_remain   <= w_remain_nxt;
            r_first    <= w_first_nxt;
            r_overflow <= r_overflow | w_drop;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_hold_nxt   = r_hold_cnt;
        w_remain_nxt = r_remain;
        w_first_nxt  = r_first;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_first_nxt  = 1'b1;
                    w_hold_nxt   = holdoff;
                    w_remain_nxt = load_count(length);
                    w_state_nxt  = (holdoff == 8'd0) ? ST_ACQ : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    w_state_nxt  = ST_IDLE;
                    w_hold_nxt   = '0;
                    w_remain_nxt = '0;
                end else if (adcsync) begin
                    w_hold_nxt = r_hold_cnt - 8'd1;
                    if (r_hold_cnt == 8'd1) w_state_nxt = ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (abort) begin
                    w_state_nxt  = ST_IDLE;
                    w_remain_nxt = '0;
                end else if (adcsync) begin
                    w_push       = 1'b1;
                    w_remain_nxt = r_remain - 9'd1;
                    // The first flag stays armed until a word actually lands in the FIFO.
                    if (!w_drop) w_first_nxt = 1'b0;
                    if (r_remain == 9'd1) w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    sync_fifo #(
        .WIDTH (c_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .din     (w_word),
        .pop     (w_pop),
        .dout    (w_fifo_dout),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    assign stream.dout       = w_fifo_dout;
    assign stream.dout_valid = !w_fifo_empty;
    assign busy              = (r_state != ST_IDLE);
    assign overflow          = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_adc_readout.sv
// ============================================================================
// Module      : tb_adc_readout
// Description : Directed scoreboard bench for adc_readout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_readout;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        adcsync;
    logic [11:0] adc_data;
    logic        adc_or;
    logic        start;
    logic        abort;
    logic [7:0]  holdoff;
    logic [7:0]  length;
    logic        busy;
    logic        overflow;

    logic [15:0] exp_q [$];
    logic [15:0] mon_exp;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    adc_readout_if u_if ();

    adc_readout #(
        .DW         (12),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .adcsync  (adcsync),
        .adc_data (adc_data),
        .adc_or   (adc_or),
        .start    (start),
        .abort    (abort),
        .holdoff  (holdoff),
        .length   (length),
        .busy     (busy),
        .overflow (overflow),
        .stream   (u_if)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // A word transfers on the next rising edge whenever valid and ready are both high here.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && u_if.dout_valid === 1'b1 && u_if.dout_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got 0x%0h expected none", u_if.dout);
            end else begin
                mon_exp = exp_q.pop_front();
                check("word", {16'h0, u_if.dout}, {16'h0, mon_exp});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic strobe(input logic [11:0] data, input logic ovr);
        adc_data = data;
        adc_or   = ovr;
        adcsync  = 1'b1;
        tick();
        adcsync  = 1'b0;
        adc_or   = 1'b0;
    endtask

    task automatic go(input logic [7:0] h, input logic [7:0] len);
        holdoff = h;
        length  = len;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        tick();
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        reset_n         = 1'b0;
        adcsync         = 1'b0;
        adc_data        = '0;
        adc_or          = 1'b0;
        start           = 1'b0;
        abort           = 1'b0;
        holdoff         = '0;
        length          = '0;
        u_if.dout_ready = 1'b0;
        idle(2);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_valid", u_if.dout_valid, 0);
        check("rst_dout", u_if.dout, 0);
        reset_n = 1'b1;
        tick();

        // Basic acquisition: two strobes skipped, three captured.
        u_if.dout_ready = 1'b1;
        exp_q.push_back(16'h8103);
        exp_q.push_back(16'h0104);
        exp_q.push_back(16'h4105);
        go(8'd2, 8'd3);
        check("t1_busy_start", busy, 1);
        strobe(12'h101, 1'b0); idle(3);
        strobe(12'h102, 1'b0); idle(3);
        strobe(12'h103, 1'b0); idle(3);
        strobe(12'h104, 1'b0);
        check("t1_busy_mid", busy, 1);
        idle(3);
        strobe(12'h105, 1'b0);
        check("t1_busy_fall", busy, 0);
        wait_drain("t1_drain", 50);
        check("t1_valid_idle", u_if.dout_valid, 0);

        // Backpressure: six samples into a four-deep FIFO.
        u_if.dout_ready = 1'b0;
        exp_q.push_back(16'h8201);
        exp_q.push_back(16'h0202);
        exp_q.push_back(16'h0203);
        exp_q.push_back(16'h0204);
        go(8'd0, 8'd6);
        for (int i = 1; i <= 6; i++) begin
            strobe(12'h200 + 12'(i), 1'b0);
            idle(1);
        end
        check("t2_busy", busy, 0);
        check("t2_overflow", overflow, 1);
        check("t2_valid", u_if.dout_valid, 1);
        check("t2_dout", u_if.dout, 16'h8201);
        idle(3);
        check("t2_dout_hold", u_if.dout, 16'h8201);
        u_if.dout_ready = 1'b1;
        wait_drain("t2_drain", 50);
        check("t2_overflow_sticky", overflow, 1);

        // Single-sample acquisition with overrange.
        exp_q.push_back(16'hEFFF);
        go(8'd0, 8'd1);
        strobe(12'hFFF, 1'b1);
        check("t3_busy", busy, 0);
        wait_drain("t3_drain", 50);

        // length=0 runs 256 samples; starts mid-run and on the falling edge are ignored.
        go(8'd0, 8'd0);
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(((i == 0) ? 16'h8000 : 16'h0000) |
                            ((i == 255) ? 16'h4000 : 16'h0000) |
                            (16'h0300 + 16'(i)));
            if (i == 100) begin
                start  = 1'b1;
                length = 8'd1;
            end
            if (i == 255) start = 1'b1;
            strobe(12'h300 + 12'(i), 1'b0);
            start = 1'b0;
            if (i == 100) check("t4_busy_100", busy, 1);
            if (i == 254) check("t4_busy_254", busy, 1);
            if (i == 255) check("t4_busy_255", busy, 0);
            idle(1);
        end
        check("t4_start_ignored", busy, 0);
        wait_drain("t4_drain", 50);

        // Abort after two samples; the abort edge also carries a strobe.
        u_if.dout_ready = 1'b0;
        exp_q.push_back(16'h8501);
        exp_q.push_back(16'h0502);
        go(8'd0, 8'd5);
        strobe(12'h501, 1'b0); idle(1);
        strobe(12'h502, 1'b0); idle(1);
        abort = 1'b1;
        strobe(12'h503, 1'b0);
        abort = 1'b0;
        check("t5_busy_abort", busy, 0);
        check("t5_valid", u_if.dout_valid, 1);
        u_if.dout_ready = 1'b1;
        wait_drain("t5_drain", 50);
        exp_q.push_back(16'h85A1);
        exp_q.push_back(16'h45A2);
        go(8'd1, 8'd2);
        check("t5_busy_restart", busy, 1);
        strobe(12'h5A0, 1'b0); idle(1);
        strobe(12'h5A1, 1'b0); idle(1);
        strobe(12'h5A2, 1'b0);
        check("t5_busy_end", busy, 0);
        wait_drain("t5_drain2", 50);

        // Reset mid-acquisition with three words queued; start during reset is dropped.
        u_if.dout_ready = 1'b0;
        go(8'd0, 8'd5);
        strobe(12'h601, 1'b0); idle(1);
        strobe(12'h602, 1'b0); idle(1);
        strobe(12'h603, 1'b0); idle(1);
        check("t6_busy_pre", busy, 1);
        check("t6_valid_pre", u_if.dout_valid, 1);
        reset_n = 1'b0;
        start   = 1'b1;
        tick();
        reset_n = 1'b1;
        start   = 1'b0;
        check("t6_valid", u_if.dout_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_overflow", overflow, 0);
        check("t6_dout", u_if.dout, 0);
        u_if.dout_ready = 1'b1;
        idle(5);
        check("t6_busy_after", busy, 0);
        check("t6_valid_after", u_if.dout_valid, 0);
        check("t6_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
